// File: rtl/mem_bus_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like memory bus.
// One transaction outstanding at a time; responses steered back to the granted master.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  state_t      state_r, state_s;
  logic        owner_r;
  logic [3:0]  streak_r;
  logic        wr_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        grant_data_s;
  logic        grant_inst_s;
  logic        grant_any_s;

  // Data wins unless inst is waiting and data has already used up its streak.
  assign grant_data_s = data_req & (~inst_req | (streak_r < LIMIT_C));
  assign grant_inst_s = inst_req & ~grant_data_s;
  assign grant_any_s  = grant_data_s | grant_inst_s;

  // Next-state logic for the single-outstanding transaction sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_any_s) state_s = ADDR;
        else             state_s = IDLE;
      end
      ADDR: begin
        if (bus_addr_ok) state_s = DATA;
        else             state_s = ADDR;
      end
      DATA: begin
        if (bus_data_ok) state_s = IDLE;
        else             state_s = DATA;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, owner, streak and latched bus fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      streak_r <= 4'd0;
      wr_r     <= 1'b0;
      size_r   <= 2'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && grant_any_s) begin
        owner_r <= grant_data_s;
        wr_r    <= grant_data_s ? data_wr    : inst_wr;
        size_r  <= grant_data_s ? data_size  : inst_size;
        addr_r  <= grant_data_s ? data_addr  : inst_addr;
        wdata_r <= grant_data_s ? data_wdata : inst_wdata;
        // Streak counts only data grants that bypassed a waiting inst request.
        if (grant_data_s && inst_req) begin
          streak_r <= (streak_r == 4'hF) ? 4'hF : streak_r + 4'd1;
        end else begin
          streak_r <= 4'd0;
        end
      end
    end
  end

  // Slave-side request and handshake steering to the owning master.
  always_comb begin
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if (state_r == ADDR) begin
      bus_req      = 1'b1;
      inst_addr_ok = bus_addr_ok & ~owner_r;
      data_addr_ok = bus_addr_ok &  owner_r;
    end else if (state_r == DATA) begin
      inst_data_ok = bus_data_ok & ~owner_r;
      data_data_ok = bus_data_ok &  owner_r;
    end else begin
      bus_req = 1'b0;
    end
  end

  assign bus_wr     = wr_r;
  assign bus_size   = size_r;
  assign bus_addr   = addr_r;
  assign bus_wdata  = wdata_r;
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter: the bench plays both masters
// and the slave, and predicts grants from a transaction-level arbitration model.
module tb_mem_bus_arbiter;
  localparam int LIMIT = 2;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, busy;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int   n_cmp = 0;
  int   n_bad = 0;
  req_t pend [2];   // 0 = inst, 1 = data
  req_t cur;
  int   data_run;   // consecutive data grants taken while inst was waiting
  int   who;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.valid = 1'b1;
    r.wr    = 1'($urandom_range(0, 1));
    r.size  = 2'($urandom_range(0, 2));
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic set_master(input int idx, input logic req, input req_t r);
    if (idx == 0) begin
      inst_req = req; inst_wr = r.wr; inst_size = r.size; inst_addr = r.addr; inst_wdata = r.wdata;
    end else begin
      data_req = req; data_wr = r.wr; data_size = r.size; data_addr = r.addr; data_wdata = r.wdata;
    end
  endtask

  // Pending masters present their request; idle masters show junk fields with req low.
  task automatic drive_masters();
    for (int i = 0; i < 2; i++) begin
      if (pend[i].valid) set_master(i, 1'b1, pend[i]);
      else               set_master(i, 1'b0, rand_req());
    end
  endtask

  task automatic check_no_ok(input string tag);
    check_eq({tag, "_inst_addr_ok"}, inst_addr_ok, 0);
    check_eq({tag, "_data_addr_ok"}, data_addr_ok, 0);
    check_eq({tag, "_inst_data_ok"}, inst_data_ok, 0);
    check_eq({tag, "_data_data_ok"}, data_data_ok, 0);
  endtask

  // One full transaction, entered at a negedge while the arbiter is idle.
  task automatic run_txn(input int aw, input int dw, input bit drop, input logic [31:0] rd,
                         output int winner);
    bit d_win;
    drive_masters();
    bus_addr_ok = 1'($urandom_range(0, 1));
    bus_data_ok = 1'($urandom_range(0, 1));
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_bus_req", bus_req, 0);
    check_no_ok("idle");
    d_win = pend[1].valid && (!pend[0].valid || data_run < LIMIT);
    winner = d_win ? 1 : 0;
    data_run = (d_win && pend[0].valid) ? data_run + 1 : 0;
    cur = pend[winner];
    pend[winner].valid = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k <= aw; k++) begin
      drive_masters();
      if (!drop) set_master(winner, 1'b1, cur);
      bus_addr_ok = (k == aw);
      bus_data_ok = 1'($urandom_range(0, 1));
      bus_rdata   = $urandom;
      #1;
      check_eq("addr_bus_req", bus_req, 1);
      check_eq("addr_busy", busy, 1);
      check_eq("addr_bus_addr", bus_addr, cur.addr);
      check_eq("addr_bus_wr", bus_wr, cur.wr);
      check_eq("addr_bus_size", bus_size, cur.size);
      check_eq("addr_bus_wdata", bus_wdata, cur.wdata);
      check_eq("inst_addr_ok", inst_addr_ok, (winner == 0) && (k == aw));
      check_eq("data_addr_ok", data_addr_ok, (winner == 1) && (k == aw));
      check_eq("addr_inst_data_ok", inst_data_ok, 0);
      check_eq("addr_data_data_ok", data_data_ok, 0);
      @(posedge clk); @(negedge clk);
    end
    for (int k = 0; k <= dw; k++) begin
      drive_masters();
      bus_data_ok = (k == dw);
      bus_addr_ok = 1'($urandom_range(0, 1));
      bus_rdata   = (k == dw) ? rd : $urandom;
      #1;
      check_eq("data_bus_req", bus_req, 0);
      check_eq("data_busy", busy, 1);
      check_eq("inst_data_ok", inst_data_ok, (winner == 0) && (k == dw));
      check_eq("data_data_ok", data_data_ok, (winner == 1) && (k == dw));
      check_eq("data_inst_addr_ok", inst_addr_ok, 0);
      check_eq("data_data_addr_ok", data_addr_ok, 0);
      if (k == dw) begin
        check_eq("inst_rdata", inst_rdata, rd);
        check_eq("data_rdata", data_rdata, rd);
      end
      @(posedge clk); @(negedge clk);
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'd0;
    pend[0] = '0; pend[1] = '0; cur = '0;
    data_run = 0;
    set_master(0, 1'b1, rand_req());
    set_master(1, 1'b1, rand_req());
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bus_wr", bus_wr, 0);
    check_eq("rst_bus_size", bus_size, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    check_no_ok("rst");
    rst = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    // Single instruction fetch from the reset vector.
    pend[0] = '{valid: 1'b1, wr: 1'b0, size: 2'd2, addr: 32'hBFC0_0000, wdata: 32'd0};
    run_txn(0, 0, 1'b0, 32'h3C08_0001, who);

    // Simultaneous requests: data first, then inst.
    pend[0] = '{valid: 1'b1, wr: 1'b0, size: 2'd2, addr: 32'h0000_1000, wdata: 32'd0};
    pend[1] = '{valid: 1'b1, wr: 1'b0, size: 2'd2, addr: 32'h0000_2000, wdata: 32'd0};
    run_txn(0, 0, 1'b0, $urandom, who);
    run_txn(0, 0, 1'b0, $urandom, who);

    // Both masters keep requesting: data, data, inst, data, data, inst.
    for (int n = 0; n < 6; n++) begin
      if (!pend[0].valid) pend[0] = rand_req();
      if (!pend[1].valid) pend[1] = rand_req();
      run_txn(0, 0, 1'b0, $urandom, who);
    end
    pend[0].valid = 1'b0; pend[1].valid = 1'b0;

    // Slave wait states.
    pend[1] = rand_req();
    run_txn(3, 5, 1'b0, $urandom, who);

    // Master drops its request during ADDR.
    pend[0] = rand_req();
    run_txn(2, 1, 1'b1, $urandom, who);

    // Data write, then reset while the response is outstanding.
    pend[1] = '{valid: 1'b1, wr: 1'b1, size: 2'd2, addr: 32'h0000_0040, wdata: 32'hDEAD_BEEF};
    drive_masters();
    @(posedge clk); @(negedge clk);
    pend[1].valid = 1'b0;
    drive_masters();
    bus_addr_ok = 1'b1;
    #1;
    check_eq("wr_bus_wr", bus_wr, 1);
    check_eq("wr_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    check_eq("wr_data_addr_ok", data_addr_ok, 1);
    @(posedge clk); @(negedge clk);
    bus_addr_ok = 1'b0;
    check_eq("wr_in_data_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    data_run = 0;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_bus_req", bus_req, 0);
    check_eq("midrst_bus_wr", bus_wr, 0);
    bus_data_ok = 1'b1;
    #1;
    check_eq("late_data_data_ok", data_data_ok, 0);
    check_eq("late_inst_data_ok", inst_data_ok, 0);
    @(posedge clk); @(negedge clk);
    bus_data_ok = 1'b0;
    check_eq("late_busy", busy, 0);

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i].valid && ($urandom_range(0, 1) == 1)) pend[i] = rand_req();
      end
      if (!pend[0].valid && !pend[1].valid) begin
        drive_masters();
        bus_addr_ok = 1'($urandom_range(0, 1));
        bus_data_ok = 1'($urandom_range(0, 1));
        #1;
        check_eq("rnd_idle_busy", busy, 0);
        check_no_ok("rnd_idle");
        @(posedge clk); @(negedge clk);
        check_eq("rnd_idle_stay", busy, 0);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      end else begin
        run_txn($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                $urandom, who);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
